// File: rtl/riscv_pkg.sv
// riscv_pkg: shared datapath widths, register-file types and the zero-register address
package riscv_pkg;
  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 5;
  localparam int NUM_REGS   = 32;
  typedef logic [31:0] word_t;
  typedef logic [4:0]  reg_addr_t;
  localparam reg_addr_t ZERO_REG = 5'd0;
endpackage

// File: rtl/regfile_read_port.sv
// regfile_read_port: one combinational read mux with zero-register masking and write bypass
// Ports: i_rst (reset, forces 0), i_regs (storage array), i_addr (read address),
//        i_wr_en/i_wr_addr/i_wr_data (pending write for bypass), o_data (read result)
module regfile_read_port #(
  parameter int DATA_WIDTH = riscv_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = riscv_pkg::ADDR_WIDTH,
  parameter int NUM_REGS   = riscv_pkg::NUM_REGS
) (
  input  logic                                i_rst,
  input  logic [NUM_REGS-1:0][DATA_WIDTH-1:0] i_regs,
  input  logic [ADDR_WIDTH-1:0]               i_addr,
  input  logic                                i_wr_en,
  input  logic [ADDR_WIDTH-1:0]               i_wr_addr,
  input  logic [DATA_WIDTH-1:0]               i_wr_data,
  output logic [DATA_WIDTH-1:0]               o_data
);
  logic w_zero;
  logic w_bypass;
  assign w_zero   = i_addr == ADDR_WIDTH'(riscv_pkg::ZERO_REG);
  // A write landing on this address this cycle is forwarded so a second-half read sees it.
  assign w_bypass = i_wr_en && i_wr_addr == i_addr;
  assign o_data   = (i_rst || w_zero) ? '0 : w_bypass ? i_wr_data : i_regs[i_addr];
endmodule

// File: rtl/register_file.sv
// register_file: 32x32 register file, two combinational read ports, one synchronous write port
// Ports: Clk, Reset (async active-high, clears all), Read_Register_1/2 -> Read_Data_1/2,
//        Write_Register/Write_Data/Sig_Reg_Write (writeback port; r0 hardwired to zero)
module register_file #(
  parameter int DATA_WIDTH = riscv_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = riscv_pkg::ADDR_WIDTH,
  parameter int NUM_REGS   = riscv_pkg::NUM_REGS
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic [ADDR_WIDTH-1:0] Read_Register_1,
  input  logic [ADDR_WIDTH-1:0] Read_Register_2,
  input  logic [ADDR_WIDTH-1:0] Write_Register,
  input  logic [DATA_WIDTH-1:0] Write_Data,
  input  logic                  Sig_Reg_Write,
  output logic [DATA_WIDTH-1:0] Read_Data_1,
  output logic [DATA_WIDTH-1:0] Read_Data_2
);
  logic [NUM_REGS-1:0][DATA_WIDTH-1:0] r_regs;
  logic                                w_wr_en;
  // Writes to r0 are dropped here, so r0 stays 0 and neither port bypasses it.
  assign w_wr_en = Sig_Reg_Write && Write_Register != ADDR_WIDTH'(riscv_pkg::ZERO_REG);
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) r_regs <= '0;
    else if (w_wr_en) r_regs[Write_Register] <= Write_Data;
  regfile_read_port #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH), .NUM_REGS(NUM_REGS)) u_rp1 (
    .i_rst(Reset), .i_regs(r_regs), .i_addr(Read_Register_1), .i_wr_en(w_wr_en),
    .i_wr_addr(Write_Register), .i_wr_data(Write_Data), .o_data(Read_Data_1));
  regfile_read_port #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH), .NUM_REGS(NUM_REGS)) u_rp2 (
    .i_rst(Reset), .i_regs(r_regs), .i_addr(Read_Register_2), .i_wr_en(w_wr_en),
    .i_wr_addr(Write_Register), .i_wr_data(Write_Data), .o_data(Read_Data_2));
endmodule

// File: tb/tb_register_file.sv
// tb_register_file: directed vectors, sweep, reset and randomized checks against an array model
`timescale 1ns/1ps
module tb_register_file;
  logic        Clk = 0;
  logic        Reset = 1;
  logic [4:0]  ra1 = 0, ra2 = 0, wa = 0;
  logic [31:0] wd = 0;
  logic        we = 0;
  logic [31:0] rd1, rd2;
  int          errors = 0, checks = 0;
  logic [31:0] model [32];
  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  ra1, ra2;
    logic [31:0] e1, e2;
  } vec_t;
  vec_t vecs [10];
  register_file dut (
    .Clk(Clk), .Reset(Reset), .Read_Register_1(ra1), .Read_Register_2(ra2),
    .Write_Register(wa), .Write_Data(wd), .Sig_Reg_Write(we),
    .Read_Data_1(rd1), .Read_Data_2(rd2));
  always #5 Clk = ~Clk;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  function automatic logic [31:0] ref_read(input logic [4:0] a);
    if (Reset || a == 0) return 0;
    if (we && wa != 0 && wa == a) return wd;
    return model[a];
  endfunction
  task automatic drive(input logic w, input logic [4:0] a, input logic [31:0] d,
                       input logic [4:0] r1, input logic [4:0] r2);
    we = w; wa = a; wd = d; ra1 = r1; ra2 = r2;
    #1;
  endtask
  task automatic commit();
    @(posedge Clk);
    if (!Reset && we && wa != 0) model[wa] = wd;
    #1;
  endtask
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
  initial begin
    logic [4:0] a;
    for (int i = 0; i < 32; i++) model[i] = 0;
    vecs[0] = '{1'b1, 5'd3, 32'd20,         5'd3, 5'd4, 32'd20,         32'd0};
    vecs[1] = '{1'b0, 5'd3, 32'd0,          5'd3, 5'd4, 32'd20,         32'd0};
    vecs[2] = '{1'b1, 5'd0, 32'd10,         5'd0, 5'd3, 32'd0,          32'd20};
    vecs[3] = '{1'b0, 5'd0, 32'd0,          5'd0, 5'd3, 32'd0,          32'd20};
    vecs[4] = '{1'b0, 5'd5, 32'hDEADBEEF,   5'd5, 5'd5, 32'd0,          32'd0};
    vecs[5] = '{1'b0, 5'd0, 32'd0,          5'd5, 5'd3, 32'd0,          32'd20};
    vecs[6] = '{1'b1, 5'd7, 32'h12345678,   5'd7, 5'd7, 32'h12345678,   32'h12345678};
    vecs[7] = '{1'b0, 5'd0, 32'd0,          5'd7, 5'd7, 32'h12345678,   32'h12345678};
    vecs[8] = '{1'b1, 5'd9, 32'h0000AAAA,   5'd3, 5'd7, 32'd20,         32'h12345678};
    vecs[9] = '{1'b0, 5'd0, 32'd0,          5'd9, 5'd0, 32'h0000AAAA,   32'd0};
    // Reset held: outputs 0 even with a bypassing write pending, and edges do not write.
    repeat (2) @(posedge Clk);
    #1;
    drive(1, 3, 32'h5, 3, 0);
    check("reset_bypass_rd1", rd1, 0);
    check("reset_rd2", rd2, 0);
    commit();
    check("reset_edge_rd1", rd1, 0);
    Reset = 0;
    drive(0, 0, 0, 3, 0);
    check("post_reset_r3", rd1, 0);
    for (int i = 0; i < 10; i++) begin
      drive(vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].ra1, vecs[i].ra2);
      check($sformatf("vec%0d_rd1", i), rd1, vecs[i].e1);
      check($sformatf("vec%0d_rd2", i), rd2, vecs[i].e2);
      commit();
    end
    drive(0, 0, 0, 7, 7);
    check("bypass_hold_rd1", rd1, 32'h12345678);
    check("bypass_hold_rd2", rd2, 32'h12345678);
    for (int i = 1; i < 32; i++) begin
      drive(1, 5'(i), 32'(i) * 32'h01010101, 0, 0);
      commit();
    end
    for (int i = 0; i < 32; i++) begin
      drive(0, 0, 0, 5'(i), 5'(31 - i));
      check($sformatf("sweep_rd1_%0d", i), rd1, 32'(i) * 32'h01010101);
      check($sformatf("sweep_rd2_%0d", i), rd2, 32'(31 - i) * 32'h01010101);
    end
    // Mid-cycle reset: every address reads 0 at once, well before the next rising edge.
    we = 1; wa = 12; wd = 32'hCAFEF00D;
    Reset = 1;
    for (int i = 0; i < 32; i++) begin
      ra1 = 5'(i); ra2 = 5'(31 - i);
      #0.2;
      check($sformatf("midreset_rd1_%0d", i), rd1, 0);
      check($sformatf("midreset_rd2_%0d", i), rd2, 0);
    end
    commit();
    Reset = 0;
    for (int i = 0; i < 32; i++) model[i] = 0;
    drive(0, 0, 0, 12, 31);
    check("after_reset_r12", rd1, 0);
    check("after_reset_r31", rd2, 0);
    for (int n = 0; n < 400; n++) begin
      a = 5'($urandom);
      drive($urandom_range(0, 3) != 0, a, $urandom,
            ($urandom_range(0, 2) == 0) ? a : 5'($urandom), 5'($urandom));
      check("rand_rd1", rd1, ref_read(ra1));
      check("rand_rd2", rd2, ref_read(ra2));
      if ($urandom_range(0, 39) == 0) begin
        Reset = 1;
        #1;
        check("rand_reset_rd1", rd1, 0);
        check("rand_reset_rd2", rd2, 0);
        commit();
        Reset = 0;
        for (int i = 0; i < 32; i++) model[i] = 0;
        #1;
        check("rand_after_reset_rd1", rd1, ref_read(ra1));
      end else commit();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
